// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: data/address widths,
// default memory latency, FSM state encoding, grant ids and a small helper.
package mem_port_arbiter_pkg;

    localparam int DEF_WORD_LEN     = 32;
    localparam int DEF_MEM_ADDR_LEN = 32;
    localparam int DEF_MEM_LATENCY  = 2;

    // Both the latency counter and the data-streak counter fit in 4 bits
    // because their legal ranges stop at 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_IF   = 1'b0,
        GNT_DATA = 1'b1
    } grant_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_timer.sv
// Loadable down-counter used to time the WAIT phase of a memory access.
// done is high whenever the count has reached zero.
module mem_latency_timer
    import mem_port_arbiter_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count;

    // Load has priority; otherwise count down while enabled, holding at zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the
// data-memory stage. One access is in flight at a time; each access walks
// IDLE -> ISSUE -> WAIT (MEM_LATENCY cycles) -> RESP. Data wins arbitration
// unless it has already taken MAX_DATA_STREAK consecutive grants while a
// fetch was waiting.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORD_LEN        = DEF_WORD_LEN,
    parameter int ADDR_LEN        = DEF_MEM_ADDR_LEN,
    parameter int MEM_LATENCY     = DEF_MEM_LATENCY,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_LEN-1:0] if_addr,
    output logic [WORD_LEN-1:0] if_rdata,
    output logic                if_ready,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [ADDR_LEN-1:0] mem_addr,
    input  logic [WORD_LEN-1:0] mem_wdata,
    output logic [WORD_LEN-1:0] mem_rdata,
    output logic                mem_ready,
    output logic                ram_en,
    output logic                ram_we,
    output logic [ADDR_LEN-1:0] ram_addr,
    output logic [WORD_LEN-1:0] ram_wdata,
    input  logic [WORD_LEN-1:0] ram_rdata,
    output logic                freeze
);

    // The timer is loaded with MEM_LATENCY-1 so that it reads zero in the
    // last of the MEM_LATENCY WAIT cycles.
    localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] MAX_STREAK = CNT_W'(MAX_DATA_STREAK);

    arb_state_t       state;
    arb_state_t       state_nxt;
    grant_t           gnt;
    logic             gnt_we;
    logic [CNT_W-1:0] streak;
    logic             arb_data;
    logic             arb_if;
    logic             timer_done;
    logic             last_wait;

    mem_latency_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (state == ISSUE),
        .load_val(LAT_LOAD),
        .en      (state == WAIT),
        .done    (timer_done)
    );

    assign last_wait = (state == WAIT) && timer_done;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the IDLE arbitration decision.
    always_comb begin
        state_nxt = state;
        arb_data  = 1'b0;
        arb_if    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req && (!if_req || (streak < MAX_STREAK))) begin
                    arb_data = 1'b1;
                end else if (if_req) begin
                    arb_if = 1'b1;
                end
                if (arb_data || arb_if) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = timer_done ? RESP : WAIT;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Data-streak counter: counts data grants that made a waiting fetch wait.
    always_ff @(posedge clk) begin
        if (!rst) begin
            streak <= '0;
        end else if (arb_data) begin
            streak <= if_req ? sat_inc(streak) : '0;
        end else if (arb_if) begin
            streak <= '0;
        end
    end

    // Latch the winner's request at grant; strobe the memory in the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            gnt       <= GNT_IF;
            gnt_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
        end else begin
            ram_en <= arb_data || arb_if;
            ram_we <= arb_data && mem_we;
            if (arb_data) begin
                gnt       <= GNT_DATA;
                gnt_we    <= mem_we;
                ram_addr  <= mem_addr;
                ram_wdata <= mem_wdata;
            end else if (arb_if) begin
                gnt       <= GNT_IF;
                gnt_we    <= 1'b0;
                ram_addr  <= if_addr;
                ram_wdata <= '0;
            end
        end
    end

    // Capture read data at the end of WAIT and pulse the owner's ready in RESP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            if_ready  <= last_wait && (gnt == GNT_IF);
            mem_ready <= last_wait && (gnt == GNT_DATA);
            if (last_wait && !gnt_we) begin
                if (gnt == GNT_DATA) begin
                    mem_rdata <= ram_rdata;
                end else begin
                    if_rdata <= ram_rdata;
                end
            end
        end
    end

    assign freeze = (if_req && !if_ready) || (mem_req && !mem_ready);

    // The two completion pulses are mutually exclusive.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(if_ready && mem_ready));
        end
    end

    // The memory strobe only ever appears in the ISSUE state.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!ram_en || (state == ISSUE));
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-timeline reference
// model and a small RAM model with MEM_LATENCY read latency.
module tb_mem_port_arbiter;

    parameter int LAT  = 2;
    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'hBAD0BAD0;
    logic        freeze;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(
        .WORD_LEN(32), .ADDR_LEN(32), .MEM_LATENCY(LAT), .MAX_DATA_STREAK(MAXS)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .freeze(freeze)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- memory model driven by the DUT ----------------
    logic [31:0] ram     [0:255];
    logic [31:0] ref_mem [0:255];
    logic [7:0]  rd_idx = '0;
    int          rd_cnt = 0;
    bit          rd_live = 0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 32'hA5000000 | i;
            ref_mem[i] = 32'hA5000000 | i;
        end
        ram[8'h04]     = 32'h2002000A;
        ref_mem[8'h04] = 32'h2002000A;
    end

    always @(posedge clk) begin
        if (rd_live && rd_cnt == 0) rd_live = 0;
        if (ram_en && ram_we) ram[ram_addr[9:2]] = ram_wdata;
        if (ram_en && !ram_we) begin
            rd_idx  = ram_addr[9:2];
            rd_cnt  = LAT;
            rd_live = 1;
        end
        if (rd_cnt > 0) rd_cnt--;
        ram_rdata <= (rd_live && rd_cnt == 0) ? ram[rd_idx] : 32'hBAD0BAD0;
    end

    // ---------------- reference model: access timeline ----------------
    // An access granted at the end of cycle t0 strobes the memory in t0+1,
    // reports ready in t0+LAT+2 and frees the port for arbitration in t0+LAT+3.
    int          cyc = 0;
    bit          model_on = 0;
    bit          busy = 0;
    int          t0 = 0;
    bit          g_data = 0;
    bit          g_we = 0;
    logic [31:0] g_rd = '0;
    int          streak = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_if_rd = '0, m_mem_rd = '0;
    bit          e_en = 0, e_we = 0, e_ifr = 0, e_memr = 0;

    always @(posedge clk) begin
        if (!rst) begin
            model_on = 1; busy = 0; streak = 0;
            m_addr = '0; m_wdata = '0; m_if_rd = '0; m_mem_rd = '0;
        end else if (model_on) begin
            if (busy && cyc == t0 + LAT + 2) begin
                busy = 0;
            end else if (busy && cyc == t0 + LAT + 1) begin
                if (!g_we) begin
                    if (g_data) m_mem_rd = g_rd;
                    else        m_if_rd  = g_rd;
                end
            end else if (!busy && (if_req || mem_req)) begin
                g_data = mem_req && (!if_req || streak < MAXS);
                if (g_data) begin
                    g_we = mem_we; m_addr = mem_addr; m_wdata = mem_wdata;
                    streak = if_req ? ((streak < 15) ? streak + 1 : 15) : 0;
                end else begin
                    g_we = 0; m_addr = if_addr; m_wdata = '0; streak = 0;
                end
                if (g_we) ref_mem[m_addr[9:2]] = m_wdata;
                else      g_rd = ref_mem[m_addr[9:2]];
                t0 = cyc; busy = 1;
            end
        end
        cyc++;
        e_en   = busy && cyc == t0 + 1;
        e_we   = e_en && g_we;
        e_ifr  = busy && cyc == t0 + LAT + 2 && !g_data;
        e_memr = busy && cyc == t0 + LAT + 2 && g_data;
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    int last_en_cyc = -1;
    int we_cnt = 0;
    always @(negedge clk) begin
        if (model_on) begin
            chk("ram_en",    32'(ram_en),    32'(e_en));
            chk("ram_we",    32'(ram_we),    32'(e_we));
            chk("ram_addr",  ram_addr,       m_addr);
            chk("ram_wdata", ram_wdata,      m_wdata);
            chk("if_ready",  32'(if_ready),  32'(e_ifr));
            chk("mem_ready", 32'(mem_ready), 32'(e_memr));
            chk("if_rdata",  if_rdata,       m_if_rd);
            chk("mem_rdata", mem_rdata,      m_mem_rd);
            chk("freeze",    32'(freeze),
                32'((if_req && !e_ifr) || (mem_req && !e_memr)));
            if (ram_en) last_en_cyc = cyc;
            if (ram_we) we_cnt++;
        end
    end

    // ---------------- requester tasks ----------------
    task automatic wait_ready(input bit is_if, output int c);
        c = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (is_if ? if_ready : mem_ready) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            checks++; errors++;
            $display("FAIL ready_timeout: is_if=%0d no ready within 200 cycles", is_if);
        end
    endtask

    task automatic fetch(input logic [31:0] a, output int s, output int d);
        if_addr = a; if_req = 1'b1; s = cyc;
        wait_ready(1'b1, d);
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic mem_acc(input bit we, input logic [31:0] a, input logic [31:0] wd,
                           output int s, output int d);
        mem_we = we; mem_addr = a; mem_wdata = wd; mem_req = 1'b1; s = cyc;
        wait_ready(1'b0, d);
        @(posedge clk); #1;
        mem_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    int s, d, s2, d2, nmem, mem_at_if;

    initial begin
        // Reset for 3 cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_if_ready", 32'(if_ready), 32'd0);
        chk("rst_ram_en",   32'(ram_en),   32'd0);
        chk("rst_ram_addr", ram_addr,      32'd0);
        chk("rst_freeze",   32'(freeze),   32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Fetch only.
        fetch(32'h10, s, d);
        chk("fetch_en_cycle",    32'(last_en_cyc - s), 32'd1);
        chk("fetch_ready_cycle", 32'(d - s),           32'(LAT + 2));
        chk("fetch_rdata",       if_rdata,             32'h2002000A);

        // Store then load to the same address.
        mem_acc(1'b1, 32'h40, 32'hDEADBEEF, s, d);
        chk("store_keeps_rdata", mem_rdata, 32'd0);
        mem_acc(1'b0, 32'h40, 32'h0, s, d);
        chk("load_after_store", mem_rdata, 32'hDEADBEEF);
        chk("we_pulses",        32'(we_cnt), 32'd1);

        // Simultaneous requests: data first, then fetch.
        fork
            mem_acc(1'b0, 32'h44, 32'h0, s, d);
            fetch(32'h14, s2, d2);
        join
        chk("simul_mem_ready", 32'(d - s),   32'(LAT + 2));
        chk("simul_if_ready",  32'(d2 - s2), 32'(2 * LAT + 5));
        chk("simul_if_rdata",  if_rdata,     32'hA5000005);

        // Starvation bound: data re-requests back to back while fetch waits.
        nmem = 0;
        fork
            begin
                for (int k = 0; k < MAXS + 1; k++) begin
                    int ss, dd;
                    mem_acc(1'b0, 32'(k * 4 + 32'h100), 32'h0, ss, dd);
                    nmem++;
                end
            end
            begin
                fetch(32'h18, s2, d2);
                mem_at_if = nmem;
            end
        join
        chk("starve_data_grants", 32'(mem_at_if), 32'(MAXS));
        chk("starve_if_cycle",    32'(d2 - s2),   32'(MAXS * (LAT + 3) + LAT + 2));

        // Reset asserted during WAIT of a load.
        mem_we = 1'b0; mem_addr = 32'h80; mem_req = 1'b1; s = cyc;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0; mem_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_mem_ready", 32'(mem_ready), 32'd0);
        chk("midrst_ram_en",    32'(ram_en),    32'd0);
        chk("midrst_mem_rdata", mem_rdata,      32'd0);
        chk("midrst_ram_addr",  ram_addr,       32'd0);
        repeat (3) @(posedge clk); #1;
        mem_acc(1'b0, 32'h80, 32'h0, s, d);
        chk("reissue_cycle", 32'(d - s), 32'(LAT + 2));
        chk("reissue_rdata", mem_rdata,  32'hA5000020);

        // Mixed traffic: 25 fetches and 25 data accesses in parallel.
        fork
            begin
                for (int k = 0; k < 25; k++) begin
                    int ss, dd;
                    fetch({22'd0, 8'($urandom_range(0, 255)), 2'b00}, ss, dd);
                end
            end
            begin
                for (int k = 0; k < 25; k++) begin
                    int ss, dd;
                    mem_acc(1'($urandom_range(0, 1)), {22'd0, 8'($urandom_range(0, 255)), 2'b00},
                            $urandom, ss, dd);
                end
            end
        join

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified memory between the instruction-fetch (IF) stage and the data-memory (MEM) stage of the MIPS pipeline. It arbitrates the two requesters, sequences each fixed-latency memory access, and returns data with a one-cycle ready pulse. It also drives the pipeline freeze signal. It sits between the IF/MEM stages and the memory model, inside the processor top level.

Parameters:
WORD_LEN, 32, data width; matches the shared `WORD_LEN define.
ADDR_LEN, 32, byte address width.
MEM_LATENCY, 2, cycles from the ram_en cycle to valid ram_rdata; legal range is 1 to 15.
MAX_DATA_STREAK, 4, maximum consecutive data grants while IF waits; legal range is 1 to 15.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-low reset
if_req  in  1  fetch request, held high until if_ready
if_addr  in  ADDR_LEN  fetch address, stable while if_req is high
if_rdata  out  WORD_LEN  fetched instruction, valid when if_ready is high
if_ready  out  1  one-cycle completion pulse for a fetch
mem_req  in  1  data request, held high until mem_ready
mem_we  in  1  1 = store, 0 = load
mem_addr  in  ADDR_LEN  data address
mem_wdata  in  WORD_LEN  store data
mem_rdata  out  WORD_LEN  load data, valid when mem_ready is high
mem_ready  out  1  one-cycle completion pulse for a data access
ram_en  out  1  memory access strobe, exactly one cycle per access
ram_we  out  1  memory write enable
ram_addr  out  ADDR_LEN  memory address
ram_wdata  out  WORD_LEN  memory write data
ram_rdata  in  WORD_LEN  memory read data
freeze  out  1  pipeline stall: (if_req & ~if_ready) | (mem_req & ~mem_ready)

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE; streak counter and latency counter clear to 0.
  - if_ready, mem_ready, ram_en, ram_we = 0; ram_addr, ram_wdata, if_rdata, mem_rdata = 0.
  - Reset overrides all other events.
- Reset asserted mid-access: the access is abandoned. No ready pulse is issued and no further ram_en is generated. Read data is discarded.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE: arbitrate at each clock edge.
  - Grant DATA if mem_req=1 and either if_req=0 or streak<MAX_DATA_STREAK.
  - Otherwise grant IF if if_req=1.
  - On a grant, latch the winner's addr/we/wdata (we forced to 0 for IF) and the grant id, then go to ISSUE.
- Streak counter:
  - On a DATA grant with if_req=1, increment (saturating).
  - On a DATA grant with if_req=0, clear.
  - On an IF grant, clear.
- ISSUE: ram_en=1 for exactly one cycle with the latched ram_we/ram_addr/ram_wdata. Load the latency counter, then go to WAIT.
- WAIT: lasts MEM_LATENCY cycles. At the edge ending the last WAIT cycle, capture ram_rdata into the granted requester's rdata register (reads only; the rdata register is unchanged on a store). Then go to RESP.
- RESP: the granted requester's ready=1 for exactly one cycle, then go to IDLE. The rdata register holds its value until the next capture.
- Latency: a request first seen in IDLE at cycle 0 gets ready in cycle MEM_LATENCY+2 (cycle 4 at the default). A new arbitration starts the cycle after RESP.
- Both requests arriving in the same cycle: DATA wins unless the streak is saturated. This gives IF a bounded wait of at most MAX_DATA_STREAK data accesses.
- Only one access is in flight at a time. Accesses are strictly serialized, so a store followed by a load to the same address returns the stored data.
- A requester dropping req mid-access is a protocol violation. The access completes, ready still pulses, and no error is flagged.
- if_ready and mem_ready are never high in the same cycle.
- ram_en never asserts outside ISSUE.
- freeze is combinational from the registered ready outputs and the requests.

Decomposition:
- Shared defines header (the existing `WORD_LEN / `REG_FILE_ADDR_LEN include): add `MEM_ADDR_LEN, `MEM_LATENCY, and the FSM state encodings IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3.
- One sub-module: mem_latency_timer. It is a loadable down-counter with load, load value, and a done flag, instantiated once for the WAIT state.

Test Plan:
- Fetch only: rst low 3 cycles then high. if_req=1, if_addr=0x10, RAM[0x10]=0x2002000A -> ram_en at cycle 1, if_ready at cycle 4, if_rdata=0x2002000A, freeze high in cycles 0-3.
- Store then load: mem_req/mem_we=1, addr 0x40, wdata 0xDEADBEEF; then a load from 0x40 -> ram_we=1 only on the store's ISSUE cycle, mem_rdata=0xDEADBEEF, mem_rdata unchanged after the store.
- Simultaneous requests: if_req and mem_req both high at cycle 0 -> data served first (mem_ready at cycle 4), fetch granted at cycle 5, if_ready at cycle 9.
- Starvation bound: mem_req held high, re-requested immediately after each ready, with if_req high -> exactly 4 data grants, then an IF grant; streak returns to 0.
- Reset mid-access: rst low during WAIT of a load -> no mem_ready pulse, all outputs 0 the next cycle, FSM in IDLE; a re-issued request completes normally in 4 cycles.
- MEM_LATENCY=1 build: fetch ready at cycle 3; ram_en is a single-cycle pulse per access (check this throughout a 50-access random mix).
